port_b_ctrl: RTL
================

# port_b_ctrl

Controller for the 8-bit PORTB pin group of the PIC16F84 model. It owns the TRIS and data latches that drive the per-pin `port_out_x1` output stages, and it sequences CPU reads and writes to them against the Q1–Q4 instruction phases. It also synchronises the pad inputs and generates the RB0/INT edge flag and the RB7:RB4 interrupt-on-change flag for the interrupt logic.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: number of flip-flop stages on `pin_in` (minimum 2).

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `q_phase` in 2: current Q phase from the clock generator (0 = Q1, 1 = Q2, 2 = Q3, 3 = Q4). Advances by one per clk.
- `sel_port` in 1: the bus access targets PORTB.
- `sel_tris` in 1: the bus access targets TRISB.
- `rd` in 1: read strobe, sampled at Q2.
- `wr` in 1: write strobe, sampled at Q4.
- `wdata` in 8: write data.
- `rdata` out 8: read data, held until the next accepted read.
- `pin_in` in 8: asynchronous pad levels.
- `tris_stat` out 8: per-pin direction (1 = input, 1'b1 per `port_out_x1` convention).
- `data_out` out 8: per-pin output latch.
- `intedg` in 1: RB0/INT edge select (1 = rising, 0 = falling).
- `intf_clr` in 1: clears `intf`.
- `rbif_clr` in 1: clears `rbif`.
- `intf` out 1: RB0/INT edge flag.
- `rbif` out 1: RB7:RB4 change flag.

## Operation

- **Reset** (asynchronous, while `rst_n` = 0):
  - `tris_stat` = 8'hFF (all pins input).
  - `data_out`, `rdata`, synchroniser chain, RB0 previous-value register and change-compare latch `cmp[7:4]` = 0.
  - `intf` = 0, `rbif` = 0.
- **Synchroniser:** `pin_in` passes through `SYNC_STAGES` flops to give `pin_s`. All pin logic uses `pin_s` only.
- **Read:** accepted on a clk edge with `q_phase` = 1, `rd` = 1 and exactly one select asserted.
  - PORTB: each `rdata[i]` = `tris_stat[i]` ? `pin_s[i]` : `data_out[i]`.
  - TRISB: `rdata` = `tris_stat`.
  - `rd` in any other phase, or with no select, leaves `rdata` unchanged.
- **Write:** accepted on a clk edge with `q_phase` = 3 and `wr` = 1.
  - `sel_tris` set: `tris_stat` loads `wdata`.
  - Only `sel_port` set: `data_out` loads `wdata`.
  - Both selects set: TRIS is written and `data_out` is unchanged.
  - `data_out` is written regardless of `tris_stat`, so the latch value appears on the pad once the pin is turned to output.
- **Interrupt-on-change:**
  - Each accepted PORTB read also loads `cmp[7:4]` ← `pin_s[7:4]`.
  - At every Q1 edge, `rbif` is set if, for any i in 7..4, `tris_stat[i]` = 1 and `pin_s[i]` ≠ `cmp[i]`.
  - Output-configured bits never set the flag.
  - `rbif_clr` clears `rbif` on any edge. If set and clear land on the same edge, set wins.
  - A persisting mismatch sets `rbif` again at the next Q1; only a PORTB read ends the mismatch.
- **RB0/INT:**
  - `prev0` ← `pin_s[0]` on every clk.
  - An edge is detected when `tris_stat[0]` = 1 and either:
    - `intedg` = 1 and `pin_s[0]` & ~`prev0`, or
    - `intedg` = 0 and ~`pin_s[0]` & `prev0`.
  - A detected edge sets `intf` on the same clk, independent of phase.
  - `intf_clr` clears `intf`. Set wins on a same-edge conflict.
  - Toggling `intedg` alone never sets `intf`.

## Timing

- Write to output: `tris_stat` / `data_out` change on the Q4 edge and are valid in the following cycle.
- Read: `rdata` is valid after the Q2 edge and holds until the next accepted read.
- Pin to `pin_s`: `SYNC_STAGES` clks.
- Pin edge to `intf` = 1: `SYNC_STAGES` + 1 clks.
- Pin change to `rbif` = 1: `SYNC_STAGES` + 1 to `SYNC_STAGES` + 4 clks, depending on when the next Q1 falls.
- `rst_n` asserted mid-instruction: all state returns to reset values immediately, and a pending write is lost. After release, operation resumes at whatever `q_phase` is presented.

## Test plan

- **Reset values:** reset, then release → `tris_stat` = FF, `data_out` = 00, `rdata` = 00, `intf` = `rbif` = 0.
- **Write then read:**
  - TRIS write 8'h0F at Q4, then PORT write 8'hA5 at Q4 → `tris_stat` = 0F, `data_out` = A5.
  - Hold `pin_in` = 8'h3C, PORT read at Q2 → `rdata` = A_C (upper nibble A5[7:4] = A, lower nibble from pins = C), i.e. 8'hAC.
- **Phase and select qualification:**
  - `wr` asserted at Q2 with `sel_port` → `data_out` unchanged.
  - Both selects with `wdata` 8'h55 at Q4 → `tris_stat` = 55, `data_out` unchanged.
- **INT edges:**
  - `intedg` = 1, pin0 0→1 → `intf` = 1 exactly 3 clks later.
  - `intf_clr` clears it.
  - `intedg` = 0 with a rising edge → `intf` stays 0.
  - `tris_stat[0]` = 0 → no flag for any edge.
- **Change interrupt:**
  - PORT read with RB7:4 = 0, then toggle RB6 → `rbif` = 1 by the next Q1 + 1 clk.
  - `rbif_clr` without a read → `rbif` re-sets at the next Q1.
  - PORT read then clear → `rbif` stays 0.
  - Toggling an output-configured RB5 → no flag.
- **Set/clear conflict and mid-cycle reset:**
  - `intf_clr` on the same edge as a detected RB0 edge → `intf` = 1.
  - `rst_n` pulsed between Q3 and Q4 of a write → `data_out` stays 00.

Source files
------------

// File: rtl/port_b_ctrl.sv
// PORTB pin-group controller: owns TRISB and the PORTB data latch, sequences
// CPU reads (Q2) and writes (Q4), synchronises the pads and raises the RB0/INT
// edge flag and the RB7:RB4 interrupt-on-change flag.
module port_b_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] q_phase,
  input  logic       sel_port,
  input  logic       sel_tris,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] pin_in,
  output logic [7:0] tris_stat,
  output logic [7:0] data_out,
  input  logic       intedg,
  input  logic       intf_clr,
  input  logic       rbif_clr,
  output logic       intf,
  output logic       rbif
);

  typedef enum logic [1:0] {
    PH_Q1 = 2'd0,
    PH_Q2 = 2'd1,
    PH_Q3 = 2'd2,
    PH_Q4 = 2'd3
  } q_phase_e;

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] pin_s;
  logic [3:0] cmp;
  logic       prev0;

  logic       rd_hit;
  logic       rd_port;
  logic       wr_hit;
  logic [7:0] port_view;
  logic       rb_set;
  logic       int_set;

  assign pin_s = sync_q[SYNC_STAGES-1];

  // Pad synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every stage is reset (it is a short flop chain, not a RAM), so
    // pin_s and the edge/change logic start from a known all-zero pad image.
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take the previous
      // stage's old value; blocking ones would collapse the chain to one flop.
      sync_q[0] <= pin_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Access qualification, read mux, and flag set conditions.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    rd_hit    = 1'b0;
    rd_port   = 1'b0;
    wr_hit    = 1'b0;
    port_view = '0;
    rb_set    = 1'b0;
    int_set   = 1'b0;

    rd_hit  = (q_phase == PH_Q2) && rd && (sel_port ^ sel_tris);
    rd_port = rd_hit && sel_port;
    wr_hit  = (q_phase == PH_Q4) && wr;

    // Input pins show the pad, output pins show the latch.
    port_view = (tris_stat & pin_s) | (~tris_stat & data_out);

    // Only input-configured RB7:RB4 bits can flag a change.
    rb_set = (q_phase == PH_Q1) &&
             (|(tris_stat[7:4] & (pin_s[7:4] ^ cmp)));

    if (tris_stat[0]) begin
      if (intedg) int_set = pin_s[0] & ~prev0;
      else        int_set = ~pin_s[0] & prev0;
    end
  end

  // TRISB and PORTB data latches; TRIS takes priority when both selects are set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tris_stat <= 8'hFF;
      data_out  <= 8'h00;
    end else if (wr_hit) begin
      if (sel_tris)      tris_stat <= wdata;
      else if (sel_port) data_out  <= wdata;
    end
  end

  // Read data register and the change-compare latch snapshot on PORTB reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 8'h00;
      cmp   <= 4'h0;
    end else if (rd_hit) begin
      rdata <= sel_port ? port_view : tris_stat;
      if (rd_port) cmp <= pin_s[7:4];
    end
  end

  // Interrupt flags: a set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev0 <= 1'b0;
      intf  <= 1'b0;
      rbif  <= 1'b0;
    end else begin
      prev0 <= pin_s[0];
      intf  <= int_set | (intf & ~intf_clr);
      rbif  <= rb_set  | (rbif & ~rbif_clr);
    end
  end

endmodule
